// File: rtl/phy_link_pkg.sv
// Shared definitions for the PHY link-training blocks.
//   link_state_e : training controller state encoding (IDLE/TRAIN/TRACK/FAIL)
//   PRBS7_*      : PRBS7 polynomial x^7 + x^6 + 1 taps and seed
//   DEFAULT_AMP  : default NRZ symbol amplitude (+AMP / -AMP)
package phy_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAIL  = 2'd3
    } link_state_e;

    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;   // x^7 term
    localparam int         PRBS7_TAP_LO = 5;   // x^6 term

    localparam int DEFAULT_AMP = 256;

    // Feedback bit of the PRBS7 register; it is also the bit issued this step.
    function automatic logic prbs7_fb(input logic [6:0] s);
        return s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
    endfunction

endpackage

// File: rtl/phy_prbs7.sv
// PRBS7 (x^7 + x^6 + 1) generator.
//   clk, rst : clock, synchronous active-high reset (reloads seed)
//   load     : reload the seed (priority over adv)
//   adv      : step the sequence by one bit
//   bit_o    : current sequence bit; advances to the next bit after an adv edge
module phy_prbs7
    import phy_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic bit_o
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = PRBS7_SEED;
        end else if (adv) begin
            lfsr_d = {lfsr_q[5:0], prbs7_fb(lfsr_q)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = prbs7_fb(lfsr_q);

endmodule

// File: rtl/phy_eq_train_ctrl.sv
// Equalizer training controller.
// Runs PRBS7-referenced training of an adaptive equalizer, switches to
// decision-directed tracking once the error has stayed small for CONV_CNT
// samples, and falls back to training when too many bad samples land in a
// monitoring window.
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse, (re)start training from any state
//   eq_valid/eq_out : equalizer output sample and its qualifier
//   train_en        : equalizer adaptation enable
//   decision_mode   : 0 = PRBS reference, 1 = slicer decision
//   ref_symbol      : reference/decision fed back to the equalizer
//   rx_bit(_valid)  : sliced bit, registered, TRACK only
//   locked / fail   : converged-and-tracking / training timeout (sticky)
//   state           : FSM state (debug)
//   retrain_cnt     : saturating count of loss-of-lock events
// Handshake: eq_out is consumed on every cycle where eq_valid=1; there is no
// backpressure. Cycles with eq_valid=0 leave every counter and the PRBS alone.
module phy_eq_train_ctrl
    import phy_link_pkg::*;
#(
    parameter int SAMPLE_W  = 10,
    parameter int AMP       = DEFAULT_AMP,
    parameter int ALIGN_DLY = 2,     // must be >= 1
    parameter int TRAIN_LEN = 4096,
    parameter int ERR_THR   = 64,
    parameter int CONV_CNT  = 128,
    parameter int WIN       = 1024,
    parameter int MAX_BAD   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       eq_valid,
    input  logic signed [SAMPLE_W-1:0] eq_out,
    output logic                       train_en,
    output logic                       decision_mode,
    output logic signed [SAMPLE_W-1:0] ref_symbol,
    output logic                       rx_bit,
    output logic                       rx_bit_valid,
    output logic                       locked,
    output logic                       fail,
    output logic [1:0]                 state,
    output logic [7:0]                 retrain_cnt
);

    localparam int ERR_W  = SAMPLE_W + 2;
    localparam int SAMP_W = $clog2(TRAIN_LEN + 1);
    localparam int GOOD_W = $clog2(CONV_CNT + 1);
    localparam int WIN_W  = $clog2(WIN + 1);
    localparam int BAD_W  = $clog2(MAX_BAD + 2);  // holds MAX_BAD+1 transiently

    localparam logic signed [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMP);
    localparam logic signed [SAMPLE_W-1:0] AMP_NEG = SAMPLE_W'(-AMP);

    link_state_e state_q, state_d;

    logic [SAMP_W-1:0]    samp_q, samp_d, samp_inc;
    logic [GOOD_W-1:0]    good_q, good_d, good_inc;
    logic [WIN_W-1:0]     win_q, win_d, win_inc;
    logic [BAD_W-1:0]     bad_q, bad_d, bad_inc;
    logic [7:0]           retrain_q, retrain_d;
    logic [ALIGN_DLY-1:0] dly_q, dly_d;
    logic [ALIGN_DLY:0]   dly_ext;
    logic                 rx_bit_q, rx_bit_valid_q;

    logic                       prbs_bit;
    logic                       slice_bit;
    logic signed [SAMPLE_W-1:0] decision, train_ref, err_ref;
    logic [ERR_W-1:0]           err, err_abs;   // two's complement error
    logic                       is_good;
    logic                       train_tick, track_tick;
    logic                       conv_hit, timeout_hit, lol_hit, win_end;
    logic                       restart_train;

    // ---------------- slicer and error ----------------
    assign slice_bit = ~eq_out[SAMPLE_W-1];
    assign decision  = slice_bit ? AMP_POS : AMP_NEG;
    // Oldest bit of the alignment line lines up with the current eq_out.
    assign train_ref = dly_q[ALIGN_DLY-1] ? AMP_POS : AMP_NEG;
    assign err_ref   = (state_q == ST_TRACK) ? decision : train_ref;

    assign err     = {{2{err_ref[SAMPLE_W-1]}}, err_ref} - {{2{eq_out[SAMPLE_W-1]}}, eq_out};
    assign err_abs = err[ERR_W-1] ? (~err + ERR_W'(1)) : err;
    assign is_good = err_abs < ERR_W'(ERR_THR);

    // ---------------- event flags ----------------
    // A start pulse swallows any sample presented on the same cycle.
    assign train_tick = eq_valid && !start && (state_q == ST_TRAIN);
    assign track_tick = eq_valid && !start && (state_q == ST_TRACK);

    assign samp_inc = samp_q + SAMP_W'(1);
    assign good_inc = good_q + GOOD_W'(1);
    assign win_inc  = win_q + WIN_W'(1);
    assign bad_inc  = bad_q + BAD_W'(!is_good);

    assign conv_hit    = train_tick && is_good && (good_inc == GOOD_W'(CONV_CNT));
    assign timeout_hit = train_tick && (samp_inc == SAMP_W'(TRAIN_LEN));
    assign lol_hit     = track_tick && (bad_inc > BAD_W'(MAX_BAD));
    assign win_end     = track_tick && (win_inc == WIN_W'(WIN));

    assign restart_train = start || lol_hit;

    phy_prbs7 u_prbs (
        .clk   (clk),
        .rst   (rst),
        .load  (restart_train),
        .adv   (train_tick),
        .bit_o (prbs_bit)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_TRAIN;
        end else begin
            unique case (state_q)
                ST_TRAIN: begin
                    // Convergence is checked first so it wins a tie with timeout.
                    if (conv_hit) begin
                        state_d = ST_TRACK;
                    end else if (timeout_hit) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_TRACK: begin
                    if (lol_hit) begin
                        state_d = ST_TRAIN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        train_en      = 1'b0;
        decision_mode = 1'b0;
        ref_symbol    = '0;
        locked        = 1'b0;
        fail          = 1'b0;
        unique case (state_q)
            ST_TRAIN: begin
                train_en   = 1'b1;
                ref_symbol = train_ref;
            end
            ST_TRACK: begin
                train_en      = 1'b1;
                decision_mode = 1'b1;
                locked        = 1'b1;
                ref_symbol    = decision;
            end
            ST_FAIL: fail = 1'b1;
            default: ;
        endcase
    end

    // ---------------- counters and alignment line ----------------
    assign dly_ext = {dly_q, prbs_bit};

    always_comb begin
        samp_d    = samp_q;
        good_d    = good_q;
        win_d     = win_q;
        bad_d     = bad_q;
        retrain_d = retrain_q;
        dly_d     = dly_q;
        if (restart_train) begin
            samp_d = '0;
            good_d = '0;
            win_d  = '0;
            bad_d  = '0;
            dly_d  = '0;
            if (lol_hit && (retrain_q != 8'hFF)) begin
                retrain_d = retrain_q + 8'd1;
            end
        end else if (train_tick) begin
            samp_d = samp_inc;
            good_d = is_good ? good_inc : '0;
            dly_d  = dly_ext[ALIGN_DLY-1:0];
            if (conv_hit) begin
                win_d = '0;
                bad_d = '0;
            end
        end else if (track_tick) begin
            if (win_end) begin
                win_d = '0;
                bad_d = '0;
            end else begin
                win_d = win_inc;
                bad_d = bad_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q         <= '0;
            good_q         <= '0;
            win_q          <= '0;
            bad_q          <= '0;
            retrain_q      <= '0;
            dly_q          <= '0;
            rx_bit_q       <= 1'b0;
            rx_bit_valid_q <= 1'b0;
        end else begin
            samp_q         <= samp_d;
            good_q         <= good_d;
            win_q          <= win_d;
            bad_q          <= bad_d;
            retrain_q      <= retrain_d;
            dly_q          <= dly_d;
            rx_bit_valid_q <= eq_valid && (state_q == ST_TRACK);
            rx_bit_q       <= eq_valid && (state_q == ST_TRACK) && slice_bit;
        end
    end

    assign rx_bit       = rx_bit_q;
    assign rx_bit_valid = rx_bit_valid_q;
    assign retrain_cnt  = retrain_q;
    assign state        = state_q;

endmodule

// File: tb/tb_phy_eq_train_ctrl.sv
module tb_phy_eq_train_ctrl;

    localparam int SW    = 10;
    localparam int AMP   = 256;
    localparam int ALIGN = 2;
    localparam int TLEN  = 4096;
    localparam int THR   = 64;
    localparam int CONV  = 128;
    localparam int WINL  = 1024;
    localparam int MAXB  = 16;

    localparam int S_IDLE = 0, S_TRAIN = 1, S_TRACK = 2, S_FAIL = 3;

    logic clk = 1'b0;
    logic rst, start, eq_valid;
    logic signed [SW-1:0] eq_out;

    logic a_train_en, a_dm, a_rx_bit, a_rxv, a_locked, a_fail;
    logic signed [SW-1:0] a_ref;
    logic [1:0] a_state;
    logic [7:0] a_retrain;

    logic b_train_en, b_dm, b_rx_bit, b_rxv, b_locked, b_fail;
    logic signed [SW-1:0] b_ref;
    logic [1:0] b_state;
    logic [7:0] b_retrain;

    phy_eq_train_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start), .eq_valid(eq_valid), .eq_out(eq_out),
        .train_en(a_train_en), .decision_mode(a_dm), .ref_symbol(a_ref),
        .rx_bit(a_rx_bit), .rx_bit_valid(a_rxv), .locked(a_locked), .fail(a_fail),
        .state(a_state), .retrain_cnt(a_retrain)
    );

    // Short training budget equal to the convergence count: tie case.
    phy_eq_train_ctrl #(.TRAIN_LEN(128), .CONV_CNT(128)) dut_b (
        .clk(clk), .rst(rst), .start(start), .eq_valid(eq_valid), .eq_out(eq_out),
        .train_en(b_train_en), .decision_mode(b_dm), .ref_symbol(b_ref),
        .rx_bit(b_rx_bit), .rx_bit_valid(b_rxv), .locked(b_locked), .fail(b_fail),
        .state(b_state), .retrain_cnt(b_retrain)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of dut_a
    int m_state, m_samp, m_good, m_win, m_bad, m_retrain, m_k;
    bit m_rx, m_rxv;
    bit prbs_hist[$];   // seven seed ones, then the PRBS7 bit stream
    int got_ref_a, got_ref_b, exp_ref;

    // PRBS7 x^7+x^6+1 as a recurrence: b[n] = b[n-7] ^ b[n-6].
    function automatic int ref_bit(int k);
        int idx = k + 7;
        while (prbs_hist.size() <= idx) begin
            int n = prbs_hist.size();
            prbs_hist.push_back(prbs_hist[n-7] ^ prbs_hist[n-6]);
        end
        return int'(prbs_hist[idx]);
    endfunction

    function automatic int model_ref(int eq);
        if (m_state == S_TRAIN) begin
            if (m_k < ALIGN) return -AMP;
            return (ref_bit(m_k - ALIGN) != 0) ? AMP : -AMP;
        end
        if (m_state == S_TRACK) return (eq >= 0) ? AMP : -AMP;
        return 0;
    endfunction

    function automatic void model_restart();
        m_state = S_TRAIN;
        m_samp = 0; m_good = 0; m_win = 0; m_bad = 0; m_k = 0;
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    // One clock: inputs set at negedge, ref captured before the edge,
    // model advanced, outputs observable on return (#1 after posedge).
    task automatic drive(input bit r, input bit st, input bit v, input int eq);
        int e;
        @(negedge clk);
        rst = r; start = st; eq_valid = v; eq_out = SW'(eq);
        #1;
        got_ref_a = int'(a_ref);
        got_ref_b = int'(b_ref);
        exp_ref   = model_ref(eq);
        if (r) begin
            m_state = S_IDLE; m_samp = 0; m_good = 0; m_win = 0; m_bad = 0;
            m_k = 0; m_retrain = 0; m_rx = 0; m_rxv = 0;
        end else begin
            m_rxv = (m_state == S_TRACK) && v;
            m_rx  = m_rxv && (eq >= 0);
            if (st) begin
                model_restart();
            end else if (v && m_state == S_TRAIN) begin
                e = exp_ref - eq;
                m_k++; m_samp++;
                m_good = (iabs(e) < THR) ? m_good + 1 : 0;
                if (m_good == CONV) begin
                    m_state = S_TRACK; m_win = 0; m_bad = 0;
                end else if (m_samp == TLEN) begin
                    m_state = S_FAIL;
                end
            end else if (v && m_state == S_TRACK) begin
                e = exp_ref - eq;
                if (iabs(e) >= THR) m_bad++;
                m_win++;
                if (m_bad > MAXB) begin
                    model_restart();
                    if (m_retrain < 255) m_retrain++;
                end else if (m_win == WINL) begin
                    m_win = 0; m_bad = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 0; start = 0; eq_valid = 0;
    endtask

    function automatic int rand_garbage();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    function automatic int rand_good_track();
        int mag = 193 + int'($urandom_range(0, 126));
        return ($urandom_range(0, 1) != 0) ? mag : -mag;
    endfunction

    task automatic test_reset();
        repeat (3) drive(1, 0, 0, 0);
        n_checks++; if (a_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", a_state); else n_pass++;
        n_checks++; if (a_train_en !== 1'b0) $display("FAIL reset_train_en: got %0b expected 0", a_train_en); else n_pass++;
        n_checks++; if (a_dm !== 1'b0) $display("FAIL reset_dm: got %0b expected 0", a_dm); else n_pass++;
        n_checks++; if (a_ref !== '0) $display("FAIL reset_ref: got %0d expected 0", a_ref); else n_pass++;
        n_checks++; if (a_locked !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", a_locked); else n_pass++;
        n_checks++; if (a_fail !== 1'b0) $display("FAIL reset_fail: got %0b expected 0", a_fail); else n_pass++;
        n_checks++; if ({a_rx_bit, a_rxv} !== 2'b00) $display("FAIL reset_rx: got %0b expected 00", {a_rx_bit, a_rxv}); else n_pass++;
        n_checks++; if (a_retrain !== 8'd0) $display("FAIL reset_retrain: got %0d expected 0", a_retrain); else n_pass++;
        n_checks++; if (b_state !== 2'd0) $display("FAIL reset_b_state: got %0d expected 0", b_state); else n_pass++;
    endtask

    task automatic test_convergence();
        drive(0, 1, 0, 0);
        n_checks++; if ({a_state, a_train_en, a_dm, a_locked} !== {2'd1, 3'b100}) $display("FAIL conv_enter_train: got %b expected 01100", {a_state, a_train_en, a_dm, a_locked}); else n_pass++;
        for (int i = 0; i < CONV; i++) begin
            if ($urandom_range(0, 2) == 0) drive(0, 0, 0, rand_garbage());
            drive(0, 0, 1, model_ref(0));
            n_checks++; if (got_ref_a !== exp_ref) $display("FAIL conv_ref[%0d]: got %0d expected %0d", i, got_ref_a, exp_ref); else n_pass++;
            if (i == CONV - 2) begin
                n_checks++; if (a_state !== 2'd1) $display("FAIL conv_early: got %0d expected 1", a_state); else n_pass++;
            end
        end
        n_checks++; if (a_state !== 2'd2) $display("FAIL conv_track: got %0d expected 2", a_state); else n_pass++;
        n_checks++; if ({a_locked, a_dm, a_train_en} !== 3'b111) $display("FAIL conv_flags: got %b expected 111", {a_locked, a_dm, a_train_en}); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, rand_good_track());
            n_checks++; if (got_ref_a !== exp_ref) $display("FAIL track_decision[%0d]: got %0d expected %0d", i, got_ref_a, exp_ref); else n_pass++;
            n_checks++; if ({a_rxv, a_rx_bit} !== {m_rxv, m_rx}) $display("FAIL track_rx[%0d]: got %b expected %b", i, {a_rxv, a_rx_bit}, {m_rxv, m_rx}); else n_pass++;
        end
        drive(0, 0, 0, rand_garbage());
        n_checks++; if (a_rxv !== 1'b0) $display("FAIL track_rx_gap: got %0b expected 0", a_rxv); else n_pass++;
    endtask

    task automatic test_loss_of_lock();
        for (int i = 0; i < MAXB + 1; i++) begin
            drive(0, 0, 1, 10);
            if (i == MAXB - 1) begin
                n_checks++; if (a_state !== 2'd2) $display("FAIL lol_early: got %0d expected 2", a_state); else n_pass++;
            end
        end
        n_checks++; if (a_state !== 2'd1) $display("FAIL lol_state: got %0d expected 1", a_state); else n_pass++;
        n_checks++; if (a_retrain !== 8'd1) $display("FAIL lol_retrain: got %0d expected 1", a_retrain); else n_pass++;
        n_checks++; if ({a_locked, a_dm, a_train_en} !== 3'b001) $display("FAIL lol_flags: got %b expected 001", {a_locked, a_dm, a_train_en}); else n_pass++;
    endtask

    task automatic test_window_clear();
        // Retraining after loss of lock restarts the PRBS from the seed.
        for (int i = 0; i < CONV; i++) begin
            drive(0, 0, 1, model_ref(0));
            n_checks++; if (got_ref_a !== exp_ref) $display("FAIL retrain_ref[%0d]: got %0d expected %0d", i, got_ref_a, exp_ref); else n_pass++;
        end
        n_checks++; if (a_state !== 2'd2) $display("FAIL win_track: got %0d expected 2", a_state); else n_pass++;
        repeat (MAXB) drive(0, 0, 1, 10);
        repeat (WINL - MAXB) drive(0, 0, 1, rand_good_track());
        repeat (MAXB) drive(0, 0, 1, -10);
        n_checks++; if (a_state !== 2'(m_state) || a_state !== 2'd2) $display("FAIL win_cleared: got %0d expected 2", a_state); else n_pass++;
        n_checks++; if (a_retrain !== 8'd1) $display("FAIL win_retrain_hold: got %0d expected 1", a_retrain); else n_pass++;
        drive(0, 0, 1, -10);
        n_checks++; if (a_state !== 2'd1) $display("FAIL win_lol: got %0d expected 1", a_state); else n_pass++;
        n_checks++; if (a_retrain !== 8'd2) $display("FAIL win_retrain2: got %0d expected 2", a_retrain); else n_pass++;
    endtask

    task automatic test_boundary();
        int r;
        drive(0, 1, 0, 0);
        for (int i = 0; i < CONV - 1; i++) begin
            r = model_ref(0);
            drive(0, 0, 1, (i % 2 == 0) ? r - 63 : r + 63);
        end
        n_checks++; if (a_state !== 2'd1) $display("FAIL bnd_63_train: got %0d expected 1", a_state); else n_pass++;
        r = model_ref(0);
        drive(0, 0, 1, r - 64);
        n_checks++; if (a_state !== 2'd1) $display("FAIL bnd_64_bad: got %0d expected 1", a_state); else n_pass++;
        for (int i = 0; i < CONV - 1; i++) begin
            if ($urandom_range(0, 1) == 0) drive(0, 0, 0, rand_garbage());
            r = model_ref(0);
            drive(0, 0, 1, r + int'($urandom_range(0, 126)) - 63);
            n_checks++; if (got_ref_a !== exp_ref) $display("FAIL bnd_ref[%0d]: got %0d expected %0d", i, got_ref_a, exp_ref); else n_pass++;
        end
        n_checks++; if (a_state !== 2'd1) $display("FAIL bnd_reset_run: got %0d expected 1", a_state); else n_pass++;
        r = model_ref(0);
        drive(0, 0, 1, r + 63);
        n_checks++; if (a_state !== 2'd2 || a_state !== 2'(m_state)) $display("FAIL bnd_conv: got %0d expected 2", a_state); else n_pass++;
    endtask

    task automatic test_timeout();
        drive(0, 1, 0, 0);
        for (int i = 0; i < TLEN; i++) begin
            drive(0, 0, 1, 0);
            if (i == TLEN - 2) begin
                n_checks++; if (a_state !== 2'd1) $display("FAIL to_early: got %0d expected 1", a_state); else n_pass++;
            end
        end
        n_checks++; if (a_state !== 2'd3) $display("FAIL to_state: got %0d expected 3", a_state); else n_pass++;
        n_checks++; if ({a_fail, a_train_en, a_dm, a_locked} !== 4'b1000) $display("FAIL to_flags: got %b expected 1000", {a_fail, a_train_en, a_dm, a_locked}); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, rand_garbage());
            n_checks++; if (got_ref_a !== 0) $display("FAIL to_hold_ref[%0d]: got %0d expected 0", i, got_ref_a); else n_pass++;
            n_checks++; if ({a_state, a_fail, a_train_en} !== 4'b1110) $display("FAIL to_hold[%0d]: got %b expected 1110", i, {a_state, a_fail, a_train_en}); else n_pass++;
        end
        drive(0, 1, 1, 0);
        n_checks++; if ({a_state, a_fail, a_train_en} !== 4'b0101) $display("FAIL to_restart: got %b expected 0101", {a_state, a_fail, a_train_en}); else n_pass++;
    endtask

    task automatic test_same_sample();
        drive(0, 1, 0, 0);
        for (int i = 0; i < CONV; i++) begin
            drive(0, 0, 1, model_ref(0));
            n_checks++; if (got_ref_b !== exp_ref) $display("FAIL tie_ref_b[%0d]: got %0d expected %0d", i, got_ref_b, exp_ref); else n_pass++;
            if (i == CONV - 2) begin
                n_checks++; if (b_state !== 2'd1) $display("FAIL tie_early: got %0d expected 1", b_state); else n_pass++;
            end
        end
        n_checks++; if (b_state !== 2'd2) $display("FAIL tie_state: got %0d expected 2", b_state); else n_pass++;
        n_checks++; if ({b_fail, b_locked} !== 2'b01) $display("FAIL tie_flags: got %b expected 01", {b_fail, b_locked}); else n_pass++;
    endtask

    task automatic test_reset_mid_track();
        n_checks++; if (a_state !== 2'd2) $display("FAIL rmt_pre: got %0d expected 2", a_state); else n_pass++;
        drive(1, 1, 1, 100);
        n_checks++; if (a_state !== 2'd0) $display("FAIL rmt_state: got %0d expected 0", a_state); else n_pass++;
        n_checks++; if ({a_train_en, a_dm, a_locked, a_fail, a_rx_bit, a_rxv} !== 6'b0) $display("FAIL rmt_flags: got %b expected 000000", {a_train_en, a_dm, a_locked, a_fail, a_rx_bit, a_rxv}); else n_pass++;
        n_checks++; if (a_ref !== '0) $display("FAIL rmt_ref: got %0d expected 0", a_ref); else n_pass++;
        n_checks++; if (a_retrain !== 8'd0) $display("FAIL rmt_retrain: got %0d expected 0", a_retrain); else n_pass++;
        n_checks++; if (b_state !== 2'd0) $display("FAIL rmt_b_state: got %0d expected 0", b_state); else n_pass++;
        drive(0, 1, 0, 0);
        for (int i = 0; i < CONV; i++) begin
            drive(0, 0, 1, model_ref(0));
            n_checks++; if (got_ref_a !== exp_ref) $display("FAIL rmt_ref_seq[%0d]: got %0d expected %0d", i, got_ref_a, exp_ref); else n_pass++;
        end
        n_checks++; if (a_state !== 2'd2) $display("FAIL rmt_reconv: got %0d expected 2", a_state); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eq_valid = 1'b0; eq_out = '0;
        repeat (7) prbs_hist.push_back(1'b1);
        m_state = S_IDLE; m_samp = 0; m_good = 0; m_win = 0; m_bad = 0;
        m_retrain = 0; m_k = 0; m_rx = 0; m_rxv = 0;
        test_reset();
        test_convergence();
        test_loss_of_lock();
        test_window_clear();
        test_boundary();
        test_timeout();
        test_same_sample();
        test_reset_mid_track();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
